// File: rtl/audio_pkg.sv
// Shared audio constants and the packed stereo sample type used by the I2S blocks.
// A packed {l, r} sample is bit-identical to an I2S frame word (left in the upper slot).
package audio_pkg;

  localparam int I2S_SLOT_BITS  = 16;
  localparam int I2S_FRAME_BITS = 32;

  typedef struct packed {
    logic signed [I2S_SLOT_BITS-1:0] l;
    logic signed [I2S_SLOT_BITS-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock divider and 5-bit bit index for the I2S transmitter.
// Strobes are combinational and mark the clk edge on which bclk falls / a frame begins.
module i2s_tx_clkgen #(
  parameter int HALF = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic       bclk,
  output logic [4:0] bit_idx,
  output logic       fall_strobe,
  output logic       frame_start
);

  localparam int               DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] divider;
  logic             toggle;

  assign toggle      = (divider == DIV_LAST);
  assign fall_strobe = toggle & bclk;
  assign frame_start = fall_strobe & (bit_idx == 5'd31);

  // Index starts at 31 so the first falling bclk edge after reset is a frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider <= '0;
      bclk    <= 1'b0;
      bit_idx <= 5'd31;
    end else begin
      if (toggle) begin
        divider <= '0;
        bclk    <= ~bclk;
      end else begin
        divider <= divider + DIV_W'(1);
      end
      if (fall_strobe) begin
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: one-entry holding register, frame shifter and valid/ready intake.
// Build option: define I2S_TX_UNDERRUN_MUTE_EN to send silence instead of repeating on underrun.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_RATE   = 24576000,
  parameter int AUDIO_RATE = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        frame_strobe,
  output logic        underrun
);

  localparam int HALF = CLK_RATE / (AUDIO_RATE * 64);

  if (HALF < 1 || (CLK_RATE % (AUDIO_RATE * 64)) != 0) begin : g_bad_rate
    $error("i2s_tx: CLK_RATE must be a non-zero exact multiple of 64*AUDIO_RATE");
  end

  logic [4:0]                bit_idx;
  logic                      fall_strobe;
  logic                      frame_start;
  logic [4:0]                slot_sel;
  logic                      hold_full;
  logic                      accept;
  stereo_sample_t            hold;
  stereo_sample_t            offered;
  logic [I2S_FRAME_BITS-1:0] frame_reg;
  logic [I2S_FRAME_BITS-1:0] underrun_fill;

  i2s_tx_clkgen #(
    .HALF(HALF)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .bclk       (i2s_bclk),
    .bit_idx    (bit_idx),
    .fall_strobe(fall_strobe),
    .frame_start(frame_start)
  );

  assign i2s_lrclk    = bit_idx[4];
  assign sample_ready = ~hold_full;
  assign accept       = sample_valid & ~hold_full;
  assign offered      = {sample_l, sample_r};

  // Next index k = bit_idx+1 wants frame bit 31-(k-1) = ~bit_idx; at the wrap
  // (bit_idx = 31) that is bit 0 of the frame still in the register, the old R LSB.
  assign slot_sel = ~bit_idx;

`ifdef I2S_TX_UNDERRUN_MUTE_EN
  assign underrun_fill = '0;
`else
  assign underrun_fill = frame_reg;
`endif

  // Frame start drains the holding register, bypasses a pair offered into an
  // empty holder, or falls back to the underrun fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold         <= '0;
      hold_full    <= 1'b0;
      frame_reg    <= '0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_strobe <= frame_start;
      underrun     <= frame_start & ~hold_full & ~sample_valid;
      if (frame_start) begin
        if (hold_full) begin
          frame_reg <= hold;
          hold_full <= 1'b0;
        end else if (sample_valid) begin
          frame_reg <= offered;
        end else begin
          frame_reg <= underrun_fill;
        end
      end else if (accept) begin
        hold      <= offered;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i2s_data <= 1'b0;
    end else if (fall_strobe) begin
      i2s_data <= frame_reg[slot_sel];
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized self-checking bench for i2s_tx: a time-based frame model is compared every cycle.
// Honours I2S_TX_UNDERRUN_MUTE_EN when the design is built with it.
module tb_i2s_tx;

  localparam int CLK_RATE   = 24576000;
  localparam int AUDIO_RATE = 48000;
  localparam int HALF       = CLK_RATE / (AUDIO_RATE * 64);
  localparam int BCLK_P     = 2 * HALF;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic        frame_strobe;
  logic        underrun;

  i2s_tx #(
    .CLK_RATE  (CLK_RATE),
    .AUDIO_RATE(AUDIO_RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_data    (i2s_data),
    .frame_strobe(frame_strobe),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: t counts clk edges since reset release; everything else follows from it.
  int          t = 0;
  logic        m_full = 1'b0;
  logic [31:0] m_hold = '0;
  logic [31:0] m_frame = '0;
  logic        m_data = 1'b0;
  logic        m_fs = 1'b0;
  logic        m_ur = 1'b0;
  logic        m_acc = 1'b0;

  logic [31:0] cur_word = '0;
  logic [31:0] words[$];
  int          fs_times[$];
  int          bclk_rises[$];
  int          lr_falls[$];
  int          ur_cnt = 0;
  int          acc_cnt = 0;
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b1;

  function automatic int k_at(int tt);
    return (31 + tt / BCLK_P) % 32;
  endfunction

  task automatic cmp(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %b, expected %b", name, t, act, exp);
    end
  endtask

  task automatic cmpInt(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(logic v, logic [15:0] l, logic [15:0] r);
    sample_valid = v;
    sample_l     = l;
    sample_r     = r;
  endtask

  task automatic modelEdge();
    int          k;
    logic [31:0] old;
    m_fs  = 1'b0;
    m_ur  = 1'b0;
    m_acc = 1'b0;
    if (reset) begin
      t       = 0;
      m_full  = 1'b0;
      m_hold  = '0;
      m_frame = '0;
      m_data  = 1'b0;
      return;
    end
    t++;
    k   = k_at(t);
    old = m_frame;
    if (t % BCLK_P == 0 && k == 0) begin
      m_fs = 1'b1;
      if (m_full) begin
        m_frame = m_hold;
        m_full  = 1'b0;
      end else if (sample_valid) begin
        m_frame = {sample_l, sample_r};
      end else begin
        m_ur    = 1'b1;
        m_frame = MUTE ? 32'h0 : m_frame;
      end
    end else if (sample_valid && !m_full) begin
      m_hold = {sample_l, sample_r};
      m_full = 1'b1;
      m_acc  = 1'b1;
    end
    if (t % BCLK_P == 0) begin
      m_data = (k == 0) ? old[0] : m_frame[32 - k];
    end
  endtask

  task automatic checkOutput();
    cmp("bclk", i2s_bclk, 1'((t / HALF) % 2));
    cmp("lrclk", i2s_lrclk, k_at(t) >= 16);
    cmp("data", i2s_data, m_data);
    cmp("ready", sample_ready, !m_full);
    cmp("frame_strobe", frame_strobe, m_fs);
    cmp("underrun", underrun, m_ur);
  endtask

  task automatic observe();
    int k;
    if (reset) begin
      words.delete();
      fs_times.delete();
      bclk_rises.delete();
      lr_falls.delete();
      cur_word  = '0;
      prev_bclk = 1'b0;
      prev_lr   = 1'b1;
      return;
    end
    if (i2s_bclk && !prev_bclk) bclk_rises.push_back(t);
    if (!i2s_lrclk && prev_lr) lr_falls.push_back(t);
    if (frame_strobe) fs_times.push_back(t);
    if (underrun) ur_cnt++;
    if (t % BCLK_P == 0) begin
      k = k_at(t);
      if (k == 0) begin
        cur_word[0] = i2s_data;
        words.push_back(cur_word);
        cur_word = '0;
      end else begin
        cur_word[32 - k] = i2s_data;
      end
    end
    prev_bclk = i2s_bclk;
    prev_lr   = i2s_lrclk;
  endtask

  task automatic step();
    if (sample_valid && sample_ready && !reset) acc_cnt++;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
    observe();
  endtask

  task automatic runUntil(int target);
    while (t < target) step();
  endtask

  initial begin
    int fs_base;
    applyStimulus(1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    repeat (3) step();
    cmp("reset_bclk", i2s_bclk, 1'b0);
    cmp("reset_lrclk", i2s_lrclk, 1'b1);
    cmp("reset_ready", sample_ready, 1'b1);
    cmp("reset_data", i2s_data, 1'b0);

    // One pair, then starve the transmitter for two frames.
    reset = 1'b0;
    applyStimulus(1'b1, 16'h8001, 16'h7FFE);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0);
    runUntil(1040);
    cmpInt("first_bclk_rise", bclk_rises[0], HALF);
    cmpInt("bclk_period", bclk_rises[1] - bclk_rises[0], 16);
    cmpInt("first_frame_strobe", fs_times[0], 16);
    cmpInt("lrclk_period", lr_falls[1] - lr_falls[0], 512);
    cmp32("serial_8001_7ffe", words[1], 32'h8001_7FFE);
    cmp32("underrun_frame", words[2], MUTE ? 32'h0 : 32'h8001_7FFE);
    cmpInt("underrun_count", ur_cnt, 2);

    // Valid held high for four frames: one acceptance per frame, no underrun.
    ur_cnt  = 0;
    acc_cnt = 0;
    fs_base = fs_times.size();
    applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    while (t < 3088) begin
      step();
      if (m_acc) applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    end
    applyStimulus(1'b0, 16'h0, 16'h0);
    cmpInt("held_valid_accepts", acc_cnt, 4);
    cmpInt("held_valid_frames", fs_times.size() - fs_base, 4);
    cmpInt("held_valid_underruns", ur_cnt, 0);

    // Pair offered exactly on the frame-start edge with the holder empty.
    runUntil(3599);
    applyStimulus(1'b1, 16'h1234, 16'hABCD);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0);
    cmp("bypass_strobe", frame_strobe, 1'b1);
    cmp("bypass_no_underrun", underrun, 1'b0);
    cmp("bypass_ready", sample_ready, 1'b1);
    runUntil(4112);
    cmp32("bypass_frame", words[8], 32'h1234_ABCD);

    // Random traffic.
    while (t < 7184) begin
      applyStimulus($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));
      step();
    end

    // Reset asserted mid-frame at k=20.
    applyStimulus(1'b1, 16'h5555, 16'hAAAA);
    while (!(k_at(t) == 20 && t % BCLK_P == 5) && t < 9000) step();
    cmpInt("reached_k20", k_at(t), 20);
    #3;
    reset = 1'b1;
    #1;
    modelEdge();
    checkOutput();
    observe();
    cmp("midreset_lrclk", i2s_lrclk, 1'b1);
    cmp("midreset_ready", sample_ready, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0);
    repeat (2) step();
    reset = 1'b0;
    runUntil(600);
    cmpInt("post_reset_first_strobe", fs_times[0], 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_RATE, default 24576000, system clock frequency in Hz.
REQ-002 SHALL have parameter AUDIO_RATE, default 48000, frame (sample-pair) rate in Hz.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port sample_l, input, 16, signed left sample.
REQ-006 SHALL have port sample_r, input, 16, signed right sample.
REQ-007 SHALL have port sample_valid, input, 1, producer offers the sample_l/sample_r pair.
REQ-008 SHALL have port sample_ready, output, 1, holding register empty; the pair is accepted when sample_valid and sample_ready are both high.
REQ-009 SHALL have port i2s_bclk, output, 1, bit clock at 32 x AUDIO_RATE.
REQ-010 SHALL have port i2s_lrclk, output, 1, word select; low = left slot.
REQ-011 SHALL have port i2s_data, output, 1, serial data, MSB first.
REQ-012 SHALL have port frame_strobe, output, 1, one-clk pulse at each frame start.
REQ-013 SHALL have port underrun, output, 1, one-clk pulse when a frame starts with no sample pair available.

Function
REQ-014 SHALL derive HALF = CLK_RATE/(AUDIO_RATE*64); toggle i2s_bclk after every HALF clk cycles; fail elaboration if HALF < 1 or the division is not exact.
REQ-015 SHALL keep a 5-bit bit index k, advanced on each clk edge that drives i2s_bclk low; i2s_lrclk = k[4], updated on that same edge.
REQ-016 SHALL define frame start as the edge where k wraps 31->0; frame_strobe pulses on that clk cycle.
REQ-017 SHALL, at frame start, move the holding register into a 32-bit frame register {L,R} and mark the holding register empty.
REQ-018 SHALL drive i2s_data only on bclk-falling edges: at k=0, the LSB of the previous frame's R; at k=1..31, frame bit 31-(k-1). This gives standard I2S one-bclk MSB delay.
REQ-019 SHALL assert sample_ready whenever the holding register is empty; acceptance fills it, and sample_ready drops on the next cycle.
REQ-020 SHALL, if the holding register is empty at frame start and a valid pair is offered on the same cycle, load that pair directly into the frame register (bypass), with no underrun and the holding register remaining empty.
REQ-021 SHALL, if no pair is available at frame start, pulse underrun and keep the previous frame contents, unless REQ-026 applies.
REQ-022 SHALL apply sample_valid only when sample_ready is high; sample_valid asserted while full is ignored and the pair is not consumed.

Reset
REQ-023 SHALL, while reset is high, set: i2s_bclk=0, divider=0, k=31, i2s_lrclk=1, i2s_data=0, frame register=0, holding register empty, sample_ready=1, frame_strobe=0, underrun=0.
REQ-024 SHALL produce, after reset release, the first bclk rise at clk cycle HALF and the first frame start at cycle 2*HALF.
REQ-025 SHALL discard any held or in-flight frame on a reset asserted mid-frame; nothing resumes after release.

Configuration
REQ-026 SHALL, when macro I2S_TX_UNDERRUN_MUTE_EN is defined, load all-zero into the frame register on underrun; without the macro, the frame repeats the last frame. The underrun pulse is produced in both cases.

Structure
REQ-027 SHALL take the constants I2S_SLOT_BITS=16 and I2S_FRAME_BITS=32, and the stereo sample struct {l,r}, from the shared package audio_pkg.
REQ-028 SHALL place the bclk divider, bit index and edge strobes in sub-module i2s_tx_clkgen; shift, holding and handshake logic stay in i2s_tx.

Verification
REQ-029 SHALL cover: defaults, reset release -> bclk period 16 clk, lrclk period 512 clk, first frame_strobe at cycle 16.
REQ-030 SHALL cover: write L=16'h8001, R=16'h7FFE before a frame -> left slot serial 1000000000000001 starting one bclk after lrclk falls, right slot 0111111111111110, with the R LSB on k=0 of the next frame.
REQ-031 SHALL cover: no writes after one pair -> underrun pulses once per frame, and the data repeats 8001/7FFE (zeros with I2S_TX_UNDERRUN_MUTE_EN).
REQ-032 SHALL cover: sample_valid held high continuously -> exactly one pair accepted per frame, sample_ready low between acceptance and frame start, and no underrun.
REQ-033 SHALL cover: valid asserted on the frame_strobe cycle with holding empty -> bypass loads that pair, no underrun, and sample_ready stays high.
REQ-034 SHALL cover: reset asserted at k=20 -> outputs take REQ-023 values immediately, and after release the first frame_strobe occurs 2*HALF cycles later.
